// File: rtl/nv_memory_pkg.sv
// Shared types for the NVM target: op codes, FSM states, error causes.
// Imported by the controller and its word array.
package nv_memory_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_PROG  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } nv_op_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    PROG,
    ERASE,
    DONE
  } nv_state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_RANGE    = 3'd1;
  localparam logic [2:0] ERR_OP       = 3'd2;
  localparam logic [2:0] ERR_LOCK     = 3'd3;
  localparam logic [2:0] ERR_OVERPROG = 3'd4;

endpackage

// File: rtl/nv_mem_array.sv
// Single-port synchronous word array for the NVM model.
// Cells are stored inverted so an all-zero power-up state reads as erased.
module nv_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] cell_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [IW-1:0]         idx;
  logic                  in_rng;

  assign idx    = addr_i[IW-1:0];
  assign in_rng = {1'b0, addr_i} < LIM;

  always_ff @(posedge clk) begin
    if (we_i && in_rng) begin
      cell_q[idx] <= ~wdata_i;
    end
    rdata_q <= ~cell_q[idx];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nv_memory_prog.sv
// Flash-style NVM target: timed read/program/page-erase behind valid/ready,
// with lower-region write protection and over-program detection.
module nv_memory_prog
  import nv_memory_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_SIZE    = 256,
  parameter int PAGE_WORDS  = 16,
  parameter int PROG_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  lock_en,
  input  logic [ADDR_WIDTH-1:0] lock_limit,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int CW = $clog2(PROG_CYCLES + 1);
  localparam int IW = $clog2(PAGE_WORDS);
  localparam logic [ADDR_WIDTH:0]   MEM_LIM  = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] PG_MASK  = ADDR_WIDTH'(PAGE_WORDS - 1);
  localparam logic [CW-1:0]         CNT_INIT = CW'(PROG_CYCLES);
  localparam logic [IW-1:0]         IDX_LAST = IW'(PAGE_WORDS - 1);

  nv_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  rdok_q, rdok_d;

  nv_op_e                op;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  in_range;
  logic [2:0]            cause;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign op       = nv_op_e'(req_op);
  assign req_base = req_addr & ~PG_MASK;
  assign in_range = {1'b0, req_addr} < MEM_LIM;

  always_comb begin
    cause = ERR_NONE;
    if (!in_range) begin
      cause = ERR_RANGE;
    end else if (op == OP_RSVD) begin
      cause = ERR_OP;
    end else if (lock_en && op == OP_PROG && req_addr < lock_limit) begin
      cause = ERR_LOCK;
    end else if (lock_en && op == OP_ERASE && req_base < lock_limit) begin
      cause = ERR_LOCK;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdok_d    = rdok_q;
    arr_we    = 1'b0;
    arr_addr  = addr_q;
    arr_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        arr_addr = req_addr;
        if (req_valid) begin
          addr_d  = (op == OP_ERASE) ? req_base : req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          idx_d   = '0;
          err_d   = (cause != ERR_NONE);
          rdok_d  = (cause == ERR_NONE) && (op == OP_READ);
          if (cause != ERR_NONE) begin
            state_d = DONE;
          end else begin
            unique case (op)
              OP_PROG:  state_d = PROG;
              OP_ERASE: state_d = ERASE;
              default:  state_d = DONE;
            endcase
          end
        end
      end
      PROG: begin
        cnt_d = cnt_q - CW'(1);
        // Commit only on the last busy cycle so a reset aborts cleanly.
        if (cnt_q == CW'(1)) begin
          arr_we    = 1'b1;
          arr_wdata = arr_rdata & wdata_q;
          err_d     = |(~arr_rdata & wdata_q);
          state_d   = DONE;
        end
      end
      ERASE: begin
        arr_we    = 1'b1;
        arr_addr  = addr_q | ADDR_WIDTH'(idx_q);
        arr_wdata = '1;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
        rdok_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdok_q  <= rdok_d;
    end
  end

  nv_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .addr_i (arr_addr),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_err   = (state_q == DONE) && err_q;
  assign rsp_rdata = (state_q == DONE && rdok_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_nv_memory_prog.sv
// Bench for nv_memory_prog: vector table, corner sequences, random ops
// checked against an array-level model of the NVM rules.
module tb_nv_memory_prog;

  localparam int MS = 128;
  localparam int PW = 16;
  localparam int PC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        lock_en;
  logic [7:0]  lock_limit;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int passed = 0;
  int total  = 0;
  logic [31:0] mdl [MS];

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [31:0] wd;
    logic        le;
    logic [7:0]  ll;
    logic        e;
    logic [31:0] rd;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  nv_memory_prog #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .MEM_SIZE   (MS),
    .PAGE_WORDS (PW),
    .PROG_CYCLES(PC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .lock_en   (lock_en),
    .lock_limit(lock_limit),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic model(input logic [1:0] op, input logic [7:0] a,
                       input logic [31:0] wd, input logic le,
                       input logic [7:0] ll, output logic e,
                       output logic [31:0] rd, output int lat);
    int base;
    base = (int'(a) / PW) * PW;
    e = 1'b0;
    rd = '0;
    lat = 1;
    if (int'(a) >= MS || op == 2'd3 ||
        (op == 2'd1 && le && a < ll) ||
        (op == 2'd2 && le && base < int'(ll))) begin
      e = 1'b1;
    end else if (op == 2'd0) begin
      rd = mdl[a];
    end else if (op == 2'd1) begin
      e = ((~mdl[a] & wd) != 0);
      mdl[a] = mdl[a] & wd;
      lat = PC + 1;
    end else begin
      for (int i = 0; i < PW; i++) mdl[base+i] = '1;
      lat = PW + 1;
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] a,
                       input logic [31:0] wd, input logic le,
                       input logic [7:0] ll);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = a;
    req_wdata  = wd;
    lock_en    = le;
    lock_limit = ll;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [7:0] a,
                       input logic [31:0] wd, input logic le,
                       input logic [7:0] ll, output logic e,
                       output logic [31:0] rd, output int lat);
    drive(op, a, wd, le, ll);
    @(posedge clk);
    #1 req_valid = 1'b0;
    e = 1'b0;
    rd = '0;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        e = rsp_err;
        rd = rsp_rdata;
        break;
      end
    end
    @(negedge clk);
    chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic add(input logic [1:0] op, input logic [7:0] a,
                     input logic [31:0] wd, input logic le,
                     input logic [7:0] ll, input logic e,
                     input logic [31:0] rd, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.wd = wd; v.le = le; v.ll = ll;
    v.e = e; v.rd = rd; v.lat = lat;
    tbl.push_back(v);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, "_err"},   {31'd0, rsp_err},   32'd0);
    chk({nm, "_rdata"}, rsp_rdata,          32'd0);
    chk({nm, "_busy"},  {31'd0, busy},      32'd0);
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        e, me;
    logic [31:0] rd, mrd;
    int          lat, mlat;
    int          n, r1, r2;
    logic [31:0] d1, d2;
    logic [1:0]  op;
    logic [7:0]  a, ll;
    logic [31:0] wd;
    logic        le;

    for (int i = 0; i < MS; i++) mdl[i] = '1;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0;
    req_wdata = '0; lock_en = 1'b0; lock_limit = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("por");
    rst_n = 1'b1;
    @(negedge clk);

    add(0, 8'h05, 0, 0, 0, 0, 32'hFFFFFFFF, 1);
    add(1, 8'h05, 32'h12345678, 0, 0, 0, 0, 5);
    add(0, 8'h05, 0, 0, 0, 0, 32'h12345678, 1);
    add(1, 8'h05, 32'h0000FFFF, 0, 0, 1, 0, 5);
    add(0, 8'h05, 0, 0, 0, 0, 32'h00005678, 1);
    add(1, 8'h10, 32'h0, 1, 8'h20, 1, 0, 1);
    add(0, 8'h10, 0, 1, 8'h20, 0, 32'hFFFFFFFF, 1);
    add(1, 8'h25, 32'h0, 0, 0, 0, 0, 5);
    add(0, 8'h25, 0, 0, 0, 0, 32'h0, 1);
    add(2, 8'h25, 0, 1, 8'h20, 0, 0, 17);
    add(0, 8'h20, 0, 0, 0, 0, 32'hFFFFFFFF, 1);
    add(0, 8'h25, 0, 0, 0, 0, 32'hFFFFFFFF, 1);
    add(0, 8'h2F, 0, 0, 0, 0, 32'hFFFFFFFF, 1);
    add(2, 8'h1F, 0, 1, 8'h20, 1, 0, 1);
    add(2, 8'h25, 0, 1, 8'h21, 1, 0, 1);
    add(1, 8'h20, 32'hA5A5A5A5, 1, 8'h20, 0, 0, 5);
    add(0, 8'h20, 0, 0, 0, 0, 32'hA5A5A5A5, 1);
    add(0, 8'hFF, 0, 0, 0, 1, 0, 1);
    add(0, 8'h80, 0, 0, 0, 1, 0, 1);
    add(0, 8'h7F, 0, 0, 0, 0, 32'hFFFFFFFF, 1);
    add(3, 8'h05, 32'hFFFFFFFF, 0, 0, 1, 0, 1);
    add(1, 8'h80, 32'h0, 0, 0, 1, 0, 1);
    add(2, 8'h85, 0, 0, 0, 1, 0, 1);
    add(2, 8'h7F, 0, 0, 0, 0, 0, 17);
    add(0, 8'h05, 0, 0, 0, 0, 32'h00005678, 1);

    foreach (tbl[k]) begin
      model(tbl[k].op, tbl[k].a, tbl[k].wd, tbl[k].le, tbl[k].ll,
            me, mrd, mlat);
      do_op(tbl[k].op, tbl[k].a, tbl[k].wd, tbl[k].le, tbl[k].ll,
            e, rd, lat);
      chk($sformatf("vec%0d_err", k), {31'd0, e}, {31'd0, tbl[k].e});
      chk($sformatf("vec%0d_rdata", k), rd, tbl[k].rd);
      chk($sformatf("vec%0d_lat", k), lat, tbl[k].lat);
    end

    // Request held across a program: the read waits for DONE+IDLE.
    drive(2'd1, 8'h40, 32'h0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    chk("hold_ready", {31'd0, req_ready}, 32'd0);
    drive(2'd0, 8'h40, 32'h0, 1'b0, 8'h00);
    model(2'd1, 8'h40, 32'h0, 1'b0, 8'h00, me, mrd, mlat);
    n = 1; r1 = -1; r2 = -1; d1 = '1; d2 = '1;
    while (n < 30 && r2 < 0) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        if (r1 < 0) begin
          r1 = n; d1 = rsp_rdata;
        end else begin
          r2 = n; d2 = rsp_rdata; req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_prog_lat", r1, 32'd5);
    chk("hold_prog_rdata", d1, 32'd0);
    chk("hold_read_lat", r2, 32'd7);
    chk("hold_read_rdata", d2, 32'd0);

    // Reset in the third PROG cycle: no write.
    drive(2'd1, 8'h50, 32'h0, 1'b0, 8'h00);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outs("prog_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(2'd0, 8'h50, 0, 0, 0, e, rd, lat);
    chk("prog_rst_word", rd, 32'hFFFFFFFF);

    // Reset in the fifth ERASE cycle: torn erase of page 0x30.
    for (int i = 0; i < PW; i++) begin
      model(2'd1, 8'(8'h30 + i), 32'h0, 1'b0, 8'h00, me, mrd, mlat);
      do_op(2'd1, 8'(8'h30 + i), 32'h0, 1'b0, 8'h00, e, rd, lat);
    end
    drive(2'd2, 8'h30, 32'h0, 1'b0, 8'h00);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outs("erase_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) mdl[8'h30+i] = '1;
    for (int i = 0; i < PW; i++) begin
      do_op(2'd0, 8'(8'h30 + i), 0, 0, 0, e, rd, lat);
      chk($sformatf("torn_%0h", 8'h30 + i), rd,
          (i < 4) ? 32'hFFFFFFFF : 32'h0);
    end

    for (int it = 0; it < 150; it++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom_range(0, 143));
      wd = $urandom_range(0, 1) ? ($urandom & mdl[a[6:0]]) : $urandom;
      le = 1'($urandom_range(0, 1));
      ll = 8'($urandom_range(0, 96));
      model(op, a, wd, le, ll, me, mrd, mlat);
      do_op(op, a, wd, le, ll, e, rd, lat);
      chk($sformatf("rnd%0d_err", it), {31'd0, e}, {31'd0, me});
      chk($sformatf("rnd%0d_rdata", it), rd, mrd);
      chk($sformatf("rnd%0d_lat", it), lat, mlat);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
